ysyx_25060170_ifetch: RTL

Instruction-fetch bus master between the PC-generating IFU and the decode stage. Accepts a fetch address from the IFU, issues a single read to instruction memory over a valid/ready request/response bus, and presents the returned instruction with its PC to the IDU. It tolerates variable memory latency, back-pressure from decode, and PC redirects (jump/flush) that arrive while a fetch is in flight.

---
 rtl/ysyx_25060170_pkg.sv | 17 +
 rtl/ysyx_25060170_inst_buf.sv | 31 +++
 rtl/ysyx_25060170_ifetch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ysyx_25060170_pkg.sv
// Shared definitions for the instruction-fetch bus master: state encoding,
// default bus widths and the alignment check width.
package ysyx_25060170_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int ALIGN_W    = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/ysyx_25060170_inst_buf.sv
// Output register presented to decode while the fetch FSM sits in HOLD.
module ysyx_25060170_inst_buf
    import ysyx_25060170_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_d,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic              err_d,
    output logic [DATA_W-1:0] data_q,
    output logic [ADDR_W-1:0] pc_q,
    output logic              err_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            pc_q   <= '0;
            err_q  <= 1'b0;
        end else if (load) begin
            data_q <= data_d;
            pc_q   <= pc_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/ysyx_25060170_ifetch.sv
// Single-outstanding instruction fetch master: IFU address in, memory read over
// valid/ready, instruction plus PC out to decode, with flush/redirect handling.
module ysyx_25060170_ifetch
    import ysyx_25060170_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    input  logic              mem_rsp_err_i,
    output logic              mem_rsp_ready_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_err_o
);

    state_t            state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              buf_load;
    logic [DATA_W-1:0] buf_data;
    logic [ADDR_W-1:0] buf_pc;
    logic              buf_err;
    logic              misaligned;

    assign misaligned = |pc_i[ALIGN_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        addr_d   = addr_q;
        buf_load = 1'b0;
        buf_data = mem_rsp_data_i;
        buf_pc   = addr_q;
        buf_err  = mem_rsp_err_i;
        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (pc_valid_i && !flush_i) begin
                    addr_d = pc_i;
                    if (misaligned) begin
                        buf_load = 1'b1;
                        buf_data = '0;
                        buf_pc   = pc_i;
                        buf_err  = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                // A request cannot be withdrawn; a flush here is remembered
                // and its response is swallowed in DRAIN.
                if (mem_req_ready_i) begin
                    state_d = (flush_i || drop_q) ? DRAIN : WAIT;
                    drop_d  = 1'b0;
                end else if (flush_i) begin
                    drop_d  = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    if (flush_i) begin
                        state_d  = IDLE;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rsp_valid_i) state_d = IDLE;
            end
            HOLD: begin
                // Handshake wins over flush: decode kills what it accepted.
                if (inst_ready_i) begin
                    if (pc_valid_i && !flush_i) begin
                        addr_d = pc_i;
                        if (misaligned) begin
                            buf_load = 1'b1;
                            buf_data = '0;
                            buf_pc   = pc_i;
                            buf_err  = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            state_d  = REQ;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_ready_o      = !rst && (flush_i || state_q == IDLE ||
                                      (state_q == HOLD && inst_ready_i));
    assign mem_req_valid_o = (state_q == REQ);
    assign mem_req_addr_o  = addr_q;
    assign mem_rsp_ready_o = (state_q == WAIT) || (state_q == DRAIN);
    assign inst_valid_o    = (state_q == HOLD);

    ysyx_25060170_inst_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_inst_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .data_d (buf_data),
        .pc_d   (buf_pc),
        .err_d  (buf_err),
        .data_q (inst_o),
        .pc_q   (inst_pc_o),
        .err_q  (inst_err_o)
    );

endmodule
